// File: rtl/icache_fetch_unit.sv
// Direct-mapped instruction cache with a three-state miss FSM.
// Hits return a word the same cycle; misses fetch a 16-byte block and fill the line.
module icache_fetch_unit #(
    parameter int NUM_BLOCKS = 8,
    parameter int ADDR_BITS  = 10
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [31:0]  PC,
    output logic [31:0]  INSTRUCTION,
    output logic         BUSYWAIT,
    output logic         MEM_READ,
    output logic [5:0]   MEM_ADDRESS,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT
);
    localparam int IW = $clog2(NUM_BLOCKS);
    localparam int BW = ADDR_BITS - 4;
    localparam int TW = BW - IW;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEM_READ,
        ST_UPDATE
    } state_t;

    state_t                  state;
    logic [BW-1:0]           miss_addr;
    logic [NUM_BLOCKS-1:0]   valid;
    logic [TW-1:0]           tags  [NUM_BLOCKS];
    logic [127:0]            lines [NUM_BLOCKS];
    logic [127:0]            fill_buf;

    logic [IW-1:0]           idx;
    logic [TW-1:0]           tag;
    logic [1:0]              offset;
    logic                    hit;
    logic [127:0]            line;
    logic                    unused_pc;

    assign idx       = PC[4+IW-1:4];
    assign tag       = PC[ADDR_BITS-1:4+IW];
    assign offset    = PC[3:2];
    assign line      = lines[idx];
    assign hit       = valid[idx] && (tags[idx] == tag);
    assign unused_pc = ^{PC[31:ADDR_BITS], PC[1:0]};

    always_comb begin
        INSTRUCTION = '0;
        if (state == ST_IDLE && hit)
            INSTRUCTION = line[offset*32 +: 32];
    end

    // Reset forces the stall low even though no line is valid yet.
    assign BUSYWAIT    = RESET && ((state != ST_IDLE) || !hit);
    assign MEM_ADDRESS = miss_addr;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= ST_IDLE;
            miss_addr <= '0;
            MEM_READ  <= 1'b0;
            valid     <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (!hit) begin
                        miss_addr <= PC[ADDR_BITS-1:4];
                        MEM_READ  <= 1'b1;
                        state     <= ST_MEM_READ;
                    end
                end
                ST_MEM_READ: begin
                    if (!MEM_BUSYWAIT) begin
                        MEM_READ <= 1'b0;
                        state    <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    valid[miss_addr[IW-1:0]] <= 1'b1;
                    state                    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Data and tags carry no reset; a line only counts once its valid bit is set.
    always_ff @(posedge CLK) begin
        if (state == ST_MEM_READ && !MEM_BUSYWAIT)
            fill_buf <= MEM_READDATA;
        if (state == ST_UPDATE && RESET) begin
            lines[miss_addr[IW-1:0]] <= fill_buf;
            tags[miss_addr[IW-1:0]]  <= miss_addr[BW-1:IW];
        end
    end
endmodule

// File: tb/tb_icache_fetch_unit.sv
// Directed and random fetch sequences against a block-level cache model.
// Memory contents are a bench-owned table indexed by block address.
module tb_icache_fetch_unit;
    logic         CLK;
    logic         RESET;
    logic [31:0]  PC;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic [5:0]   MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;

    int checks   = 0;
    int failures = 0;

    logic [127:0] memv [64];
    logic         m_valid [8];
    logic [5:0]   m_blk   [8];

    icache_fetch_unit dut (
        .CLK(CLK),
        .RESET(RESET),
        .PC(PC),
        .INSTRUCTION(INSTRUCTION),
        .BUSYWAIT(BUSYWAIT),
        .MEM_READ(MEM_READ),
        .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_READDATA(MEM_READDATA),
        .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        logic [127:0] b;
        b = memv[pc[9:4]];
        return b[pc[3:2]*32 +: 32];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    endtask

    // One fetch: hit expected -> immediate word; miss -> full fill sequence.
    task automatic fetch(input logic [31:0] pc, input int nbusy,
                         input logic [31:0] dpc);
        logic [5:0] blk;
        logic [2:0] li;
        logic       exp_hit;
        int         edges;
        int         mr;
        int         k;
        blk = pc[9:4];
        li  = blk[2:0];
        exp_hit = m_valid[li] && (m_blk[li] == blk);
        @(negedge CLK);
        PC           = pc;
        MEM_BUSYWAIT = 1'b1;
        MEM_READDATA = memv[blk];
        #1;
        chk("busy_at_lookup", {31'd0, BUSYWAIT}, {31'd0, !exp_hit});
        if (!exp_hit) begin
            edges = 0;
            mr    = 0;
            k     = 0;
            while (BUSYWAIT && edges < 200) begin
                @(posedge CLK);
                edges++;
                @(negedge CLK);
                if (MEM_READ) begin
                    if (mr == 0)
                        chk("mem_address", {26'd0, MEM_ADDRESS}, {26'd0, blk});
                    mr++;
                    PC           = dpc;
                    MEM_BUSYWAIT = (k < nbusy);
                    k++;
                end else begin
                    PC = pc;
                end
                #1;
            end
            chk("miss_edges", edges, nbusy + 3);
            chk("mem_read_cycles", mr, nbusy + 1);
            m_valid[li] = 1'b1;
            m_blk[li]   = blk;
        end
        chk("busy_done", {31'd0, BUSYWAIT}, 32'd0);
        chk("mem_read_idle", {31'd0, MEM_READ}, 32'd0);
        chk("instruction", INSTRUCTION, word_of(pc));
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_busy"}, {31'd0, BUSYWAIT}, 32'd0);
        chk({name, "_mem_read"}, {31'd0, MEM_READ}, 32'd0);
        chk({name, "_addr"}, {26'd0, MEM_ADDRESS}, 32'd0);
        chk({name, "_instr"}, INSTRUCTION, 32'd0);
    endtask

    initial begin
        logic [31:0] rpc;
        for (int i = 0; i < 64; i++)
            memv[i] = {$urandom, $urandom, $urandom, $urandom};
        memv[0] = {32'h4, 32'h3, 32'h2, 32'h1};
        model_reset();
        PC           = 32'h0;
        MEM_BUSYWAIT = 1'b1;
        MEM_READDATA = '0;
        RESET        = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge CLK);
        RESET = 1'b1;

        // cold miss then sequential hits
        fetch(32'h000, 5, 32'h000);
        chk("word0", INSTRUCTION, 32'h1);
        fetch(32'h004, 0, 32'h004);
        chk("word1", INSTRUCTION, 32'h2);
        fetch(32'h008, 0, 32'h008);
        fetch(32'h00C, 0, 32'h00C);
        chk("word3", INSTRUCTION, 32'h4);

        // conflict eviction on index 1
        fetch(32'h010, 2, 32'h010);
        fetch(32'h090, 1, 32'h090);
        fetch(32'h010, 0, 32'h010);

        // reset while waiting on memory
        @(negedge CLK);
        PC           = 32'h050;
        MEM_BUSYWAIT = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk("midfill_mem_read", {31'd0, MEM_READ}, 32'd1);
        RESET = 1'b0;
        #1;
        check_reset_outputs("midfill");
        model_reset();
        @(negedge CLK);
        RESET = 1'b1;
        fetch(32'h050, 1, 32'h050);

        // PC disturbance while filling
        fetch(32'h020, 3, 32'h3F0);
        fetch(32'h024, 0, 32'h024);

        // zero-wait memory and wrap-around address
        fetch(32'hFFFF_FFFC, 0, 32'hFFFF_FFFC);
        chk("wrap_word", INSTRUCTION, memv[63][127:96]);

        // reset coincident with the MEM_READ exit edge
        @(negedge CLK);
        PC           = 32'h040;
        MEM_BUSYWAIT = 1'b0;
        MEM_READDATA = memv[4];
        @(posedge CLK);
        @(negedge CLK);
        chk("collide_mem_read", {31'd0, MEM_READ}, 32'd1);
        @(posedge CLK);
        RESET = 1'b0;
        #1;
        check_reset_outputs("collide");
        model_reset();
        @(negedge CLK);
        RESET = 1'b1;
        fetch(32'h040, 0, 32'h040);

        // random traffic against the model
        for (int i = 0; i < 60; i++) begin
            rpc = {$urandom} & 32'hFFFF_F0FC;
            rpc[9:4] = 6'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            fetch(rpc, $urandom_range(0, 3), rpc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
